// File: rtl/div128_64_pkg.sv
// div128_64_pkg: shared definitions for the sequential restoring divider.
//   state_t      : FSM encoding (IDLE / RUN / DONE)
//   DW_DEFAULT   : default divisor/remainder width (dividend/quotient are 2*DW)
//   CNTW_DEFAULT : default iteration counter width (2^CNTW must exceed 2*DW)
package div128_64_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DW_DEFAULT   = 64;
  localparam int CNTW_DEFAULT = 8;

endpackage

// File: rtl/div128_64_div_step.sv
// div_step: one combinational restoring-division step.
//   p_in     in  DW+1  current partial remainder P
//   next_bit in  1     next dividend bit shifted into P
//   divisor  in  DW    divisor
//   p_out    out DW+1  next partial remainder P'
//   qbit     out 1     quotient bit produced by this step
module div_step
  import div128_64_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW:0]   p_in,
  input  logic          next_bit,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   p_out,
  output logic          qbit
);

  logic [DW:0] t;

  // Shift the next dividend bit into P and subtract the divisor when it fits.
  // p_in[DW] is always 0 in a well-formed run (P < divisor); if it were set the
  // shifted value would exceed DW+1 bits, so the subtraction is mandatory.
  always_comb begin
    t = {p_in[DW-1:0], next_bit};
    if (p_in[DW] || (t >= {1'b0, divisor})) begin
      qbit  = 1'b1;
      p_out = t - {1'b0, divisor};
    end else begin
      qbit  = 1'b0;
      p_out = t;
    end
  end

endmodule

// File: rtl/div128_64.sv
// div128_64: sequential restoring divider, one quotient bit per clock.
//   clk       in  1     rising-edge clock
//   rst       in  1     asynchronous active-high reset
//   start     in  1     request, accepted only while busy=0
//   dividend  in  2*DW  sampled on the accepting edge
//   divisor   in  DW    sampled on the accepting edge
//   busy      out 1     operation in progress
//   done      out 1     one-cycle pulse, results valid
//   div_zero  out 1     divisor was zero (valid with done, held with results)
//   quotient  out 2*DW  held from done until the next accepted start
//   remainder out DW    held from done until the next accepted start
module div128_64
  import div128_64_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [2*DW-1:0]   quotient,
  output logic [DW-1:0]     remainder
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(2*DW-1);
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_t              state;
  logic [2*DW-1:0]     s_reg;   // dividend shifting out, quotient shifting in
  logic [DW:0]         p_reg;   // partial remainder
  logic [DW-1:0]       dvs;     // latched divisor
  logic [CNTW-1:0]     cnt;
  logic [DW:0]         p_next;
  logic                qbit;

  div_step #(.DW(DW)) u_step (
    .p_in     (p_reg),
    .next_bit (s_reg[2*DW-1]),
    .divisor  (dvs),
    .p_out    (p_next),
    .qbit     (qbit)
  );

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      s_reg     <= {(2*DW){1'b0}};
      p_reg     <= {(DW+1){1'b0}};
      dvs       <= {DW{1'b0}};
      cnt       <= {CNTW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= {(2*DW){1'b0}};
      remainder <= {DW{1'b0}};
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            s_reg    <= dividend;
            p_reg    <= {(DW+1){1'b0}};
            dvs      <= divisor;
            cnt      <= {CNTW{1'b0}};
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (dvs == {DW{1'b0}}) begin
            // Zero divisor: finish on the first step edge; s_reg still holds
            // the untouched dividend, so its low half becomes the remainder.
            quotient  <= {(2*DW){1'b1}};
            remainder <= s_reg[DW-1:0];
            div_zero  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            s_reg <= {s_reg[2*DW-2:0], qbit};
            p_reg <= p_next;
            cnt   <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              quotient  <= {s_reg[2*DW-2:0], qbit};
              remainder <= p_next[DW-1:0];
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div128_64.sv
// tb_div128_64: scoreboard bench for div128_64 (DW=64). Stimulus pushes the
// arithmetically computed expected result; a negedge monitor pops and compares
// whenever done is seen, also checking latency, done/busy exclusion and that
// quotient/remainder hold between completions.
module tb_div128_64;

  typedef struct {
    logic [127:0] dd;
    logic [63:0]  dv;
    logic [127:0] q;
    logic [63:0]  r;
    logic         dz;
    longint       acc;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] dividend;
  logic [63:0]  divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [127:0] quotient;
  logic [63:0]  remainder;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  longint       cyc = 0;
  logic [127:0] hq = 128'h0;
  logic [63:0]  hr = 64'h0;

  div128_64 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hq = 128'h0;
      hr = 64'h0;
    end else if (done) begin
      chk("done_with_busy", {127'h0, busy}, 128'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 128'h1, 128'h0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", {64'h0, remainder}, {64'h0, e.r});
        chk("div_zero", {127'h0, div_zero}, {127'h0, e.dz});
        chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        if (!e.dz) begin
          chk("identity", quotient * {64'h0, e.dv} + {64'h0, remainder}, e.dd);
          chk("rem_lt_div", {127'h0, (remainder < e.dv)}, 128'h1);
        end
      end
      hq = quotient;
      hr = remainder;
    end else begin
      chk("hold_q", quotient, hq);
      chk("hold_r", {64'h0, remainder}, {64'h0, hr});
    end
  end

  // Issue one operation once the divider can accept it (called at negedge+1).
  task automatic issue(input logic [127:0] dd, input logic [63:0] dv);
    exp_t e;
    int g = 0;
    while (busy && g < 300) begin
      @(negedge clk); #1;
      g++;
    end
    if (busy) chk("issue_timeout", 128'h1, 128'h0);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    e.dd  = dd;
    e.dv  = dv;
    e.dz  = (dv == 64'h0);
    e.q   = e.dz ? {128{1'b1}} : dd / {64'h0, dv};
    e.r   = e.dz ? dd[63:0] : 64'(dd % {64'h0, dv});
    e.acc = cyc + 1;
    e.lat = e.dz ? 1 : 128;
    exp_q.push_back(e);
    @(negedge clk); #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom, $urandom, $urandom};
    divisor  = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      chk("completion_timeout", 128'h1, 128'h0);
      exp_q.delete();
    end
  endtask

  function automatic logic [63:0] rnd_divisor();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'($urandom_range(1, 255));
      1: v = {1'b1, 31'($urandom), $urandom};
      2: v = {1'b0, 31'($urandom), $urandom};
      3: v = 64'h0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic logic [127:0] rnd_dividend();
    logic [127:0] v;
    case ($urandom_range(0, 3))
      0: v = 128'($urandom);
      1: v = {64'h0, $urandom, $urandom};
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0]  dmax;
    logic [127:0] dsq;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 128'h0;
    divisor  = 64'h0;
    #1;
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_done", {127'h0, done}, 128'h0);
    chk("rst_div_zero", {127'h0, div_zero}, 128'h0);
    chk("rst_quotient", quotient, 128'h0);
    chk("rst_remainder", {64'h0, remainder}, 128'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Directed cases
    issue(128'd100, 64'd7);
    issue({128{1'b1}}, 64'd1);
    issue(128'h1234, 64'h0);
    dmax = {64{1'b1}};
    dsq  = {64'h0, dmax} * {64'h0, dmax} + 128'd5;
    issue(dsq, dmax);
    wait_idle();

    // start while busy is ignored
    issue(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 64'h0000_0001_2345_6789);
    repeat (10) @(negedge clk);
    #1;
    start    = 1'b1;
    dividend = 128'd999;
    divisor  = 64'd3;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Reset mid-operation
    issue(128'hDEAD_BEEF_0000_0000_CAFE_F00D_1234_5678, 64'h8000_0000_0000_0003);
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", {127'h0, busy}, 128'h0);
    chk("midrst_done", {127'h0, done}, 128'h0);
    chk("midrst_quotient", quotient, 128'h0);
    chk("midrst_remainder", {64'h0, remainder}, 128'h0);
    exp_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    issue(128'd100, 64'd7);
    wait_idle();

    // Random back-to-back operations
    for (int i = 0; i < 300; i++) begin
      issue(rnd_dividend(), rnd_divisor());
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
